tone_sequencer: RTL and testbench



---
 rtl/tone_sequencer.sv | 172 +++++++++++++++++
 tb/tb_tone_sequencer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/tone_sequencer.sv
// Square-wave note player: accepts one note descriptor, plays it for len ticks,
// then holds silence for GAP_TICKS ticks before pulsing done.
module tone_sequencer #(
  parameter int TICK_DIV  = 40000,
  parameter int GAP_TICKS = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        note_valid,
  output logic        note_ready,
  input  logic [19:0] note_div,
  input  logic [15:0] note_len,
  input  logic [3:0]  note_vol,
  input  logic [1:0]  note_pan,
  output logic [15:0] au_in_left,
  output logic [15:0] au_in_right,
  output logic        busy,
  output logic        done
);

  localparam int              TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0]   TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [15:0]     GAP_LAST  = 16'(GAP_TICKS - 1);

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  state_t        state_q, state_d;
  logic [19:0]   hcnt_q, hcnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [15:0]   mcnt_q, mcnt_d;
  logic          phase_q, phase_d;
  logic [19:0]   div_q, div_d;
  logic [15:0]   len_q, len_d;
  logic [3:0]    vol_q, vol_d;
  logic [1:0]    pan_q, pan_d;
  logic [15:0]   left_q, left_d;
  logic [15:0]   right_q, right_d;
  logic          done_q, done_d;
  logic          tick_wrap;
  logic [15:0]   sample;

  // Signed square-wave level for a phase; a rest (div==0) is silent.
  function automatic logic [15:0] level(input logic ph, input logic [3:0] vol,
                                        input logic [19:0] div);
    logic [15:0] a;
    a = {1'b0, vol, 11'b0};
    if (div == 20'd0) return 16'd0;
    return ph ? a : (~a + 16'd1);
  endfunction

  assign tick_wrap = (tcnt_q == TICK_LAST);

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    tcnt_d  = tcnt_q;
    mcnt_d  = mcnt_q;
    phase_d = phase_q;
    div_d   = div_q;
    len_d   = len_q;
    vol_d   = vol_q;
    pan_d   = pan_q;
    left_d  = 16'd0;
    right_d = 16'd0;
    done_d  = 1'b0;
    sample  = 16'd0;

    case (state_q)
      IDLE: begin
        if (note_valid) begin
          div_d   = note_div;
          len_d   = note_len;
          vol_d   = note_vol;
          pan_d   = note_pan;
          hcnt_d  = 20'd0;
          tcnt_d  = '0;
          mcnt_d  = 16'd0;
          phase_d = 1'b1;
          if (note_len == 16'd0) begin
            state_d = GAP;
          end else begin
            state_d = PLAY;
            sample  = level(1'b1, note_vol, note_div);
            left_d  = note_pan[1] ? 16'd0 : sample;
            right_d = note_pan[0] ? 16'd0 : sample;
          end
        end
      end

      PLAY: begin
        if (div_q != 20'd0) begin
          if (hcnt_q == div_q - 20'd1) begin
            hcnt_d  = 20'd0;
            phase_d = ~phase_q;
          end else begin
            hcnt_d  = hcnt_q + 20'd1;
          end
        end
        sample  = level(phase_d, vol_q, div_q);
        left_d  = pan_q[1] ? 16'd0 : sample;
        right_d = pan_q[0] ? 16'd0 : sample;
        if (tick_wrap) begin
          tcnt_d = '0;
          // Duration end wins over a coincident phase toggle: outputs go silent.
          if (mcnt_q == len_q - 16'd1) begin
            state_d = GAP;
            mcnt_d  = 16'd0;
            left_d  = 16'd0;
            right_d = 16'd0;
          end else begin
            mcnt_d  = mcnt_q + 16'd1;
          end
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end

      GAP: begin
        if (GAP_TICKS == 0 || (tick_wrap && mcnt_q == GAP_LAST)) begin
          state_d = IDLE;
          done_d  = 1'b1;
          tcnt_d  = '0;
          mcnt_d  = 16'd0;
        end else if (tick_wrap) begin
          tcnt_d = '0;
          mcnt_d = mcnt_q + 16'd1;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      hcnt_q  <= 20'd0;
      tcnt_q  <= '0;
      mcnt_q  <= 16'd0;
      phase_q <= 1'b0;
      div_q   <= 20'd0;
      len_q   <= 16'd0;
      vol_q   <= 4'd0;
      pan_q   <= 2'd0;
      left_q  <= 16'd0;
      right_q <= 16'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      tcnt_q  <= tcnt_d;
      mcnt_q  <= mcnt_d;
      phase_q <= phase_d;
      div_q   <= div_d;
      len_q   <= len_d;
      vol_q   <= vol_d;
      pan_q   <= pan_d;
      left_q  <= left_d;
      right_q <= right_d;
      done_q  <= done_d;
    end
  end

  assign note_ready  = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign au_in_left  = left_q;
  assign au_in_right = right_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer with TICK_DIV=10, GAP_TICKS=2.
module tb_tone_sequencer;

  localparam int TD  = 10;
  localparam int GT  = 2;
  localparam int NV  = 9;

  logic        clk;
  logic        rst;
  logic        note_valid;
  logic        note_ready;
  logic [19:0] note_div;
  logic [15:0] note_len;
  logic [3:0]  note_vol;
  logic [1:0]  note_pan;
  logic [15:0] au_in_left;
  logic [15:0] au_in_right;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [19:0] div;
    logic [15:0] len;
    logic [3:0]  vol;
    logic [1:0]  pan;
    logic [15:0] hl;   // left during phase 1
    logic [15:0] hr;   // right during phase 1
    logic [15:0] ll;   // left during phase 0
    logic [15:0] lr;   // right during phase 0
  } vec_t;

  vec_t vecs [NV];
  vec_t vb;

  tone_sequencer #(.TICK_DIV(TD), .GAP_TICKS(GT)) dut (
    .clk        (clk),
    .rst        (rst),
    .note_valid (note_valid),
    .note_ready (note_ready),
    .note_div   (note_div),
    .note_len   (note_len),
    .note_vol   (note_vol),
    .note_pan   (note_pan),
    .au_in_left (au_in_left),
    .au_in_right(au_in_right),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered at the observation right after the accept edge; runs through done.
  task automatic play_check(input vec_t v, input string tag);
    int p;
    logic [15:0] el, er;
    p = int'(v.len) * TD;
    for (int k = 0; k < p + GT * TD; k++) begin
      el = 16'd0;
      er = 16'd0;
      if (k < p && v.div != 20'd0) begin
        if (((k / int'(v.div)) % 2) == 0) begin
          el = v.hl; er = v.hr;
        end else begin
          el = v.ll; er = v.lr;
        end
      end
      chk($sformatf("%s k%0d busy", tag, k), {31'd0, busy}, 32'd1);
      chk($sformatf("%s k%0d left", tag, k), {16'd0, au_in_left}, {16'd0, el});
      chk($sformatf("%s k%0d right", tag, k), {16'd0, au_in_right}, {16'd0, er});
      chk($sformatf("%s k%0d done", tag, k), {31'd0, done}, 32'd0);
      step();
    end
    chk($sformatf("%s end done", tag), {31'd0, done}, 32'd1);
    chk($sformatf("%s end ready", tag), {31'd0, note_ready}, 32'd1);
    chk($sformatf("%s end busy", tag), {31'd0, busy}, 32'd0);
    step();
    chk($sformatf("%s done width", tag), {31'd0, done}, 32'd0);
    $display("note %s: div=%0d len=%0d vol=%0d pan=%b checked", tag, v.div, v.len, v.vol, v.pan);
  endtask

  task automatic drive(input vec_t v);
    note_div = v.div;
    note_len = v.len;
    note_vol = v.vol;
    note_pan = v.pan;
  endtask

  task automatic send_and_check(input vec_t v, input string tag);
    drive(v);
    note_valid = 1'b1;
    step();
    note_valid = 1'b0;
    play_check(v, tag);
  endtask

  initial begin
    vecs[0] = '{20'd4, 16'd3, 4'd15, 2'b00, 16'h7800, 16'h7800, 16'h8800, 16'h8800};
    vecs[1] = '{20'd0, 16'd2, 4'd8,  2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    vecs[2] = '{20'd1, 16'd1, 4'd1,  2'b01, 16'h0800, 16'h0000, 16'hF800, 16'h0000};
    vecs[3] = '{20'd1, 16'd1, 4'd1,  2'b10, 16'h0000, 16'h0800, 16'h0000, 16'hF800};
    vecs[4] = '{20'd1, 16'd1, 4'd1,  2'b11, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    vecs[5] = '{20'd3, 16'd0, 4'd7,  2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    vecs[6] = '{20'd5, 16'd1, 4'd15, 2'b00, 16'h7800, 16'h7800, 16'h8800, 16'h8800};
    vecs[7] = '{20'd3, 16'd1, 4'd0,  2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    vecs[8] = '{20'd2, 16'd2, 4'd9,  2'b00, 16'h4800, 16'h4800, 16'hB800, 16'hB800};
    vb      = '{20'd2, 16'd1, 4'd3,  2'b00, 16'h1800, 16'h1800, 16'hE800, 16'hE800};

    rst        = 1'b1;
    note_valid = 1'b0;
    note_div   = 20'd0;
    note_len   = 16'd0;
    note_vol   = 4'd0;
    note_pan   = 2'd0;
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("reset left", {16'd0, au_in_left}, 32'd0);
    chk("reset right", {16'd0, au_in_right}, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset ready", {31'd0, note_ready}, 32'd1);

    for (int i = 0; i < NV; i++) begin
      send_and_check(vecs[i], $sformatf("v%0d", i));
    end

    // len=0 note with note_valid held high: the second note must wait for IDLE.
    drive(vecs[5]);
    note_valid = 1'b1;
    step();
    drive(vb);
    for (int k = 0; k < GT * TD; k++) begin
      chk($sformatf("hold k%0d busy", k), {31'd0, busy}, 32'd1);
      chk($sformatf("hold k%0d ready", k), {31'd0, note_ready}, 32'd0);
      chk($sformatf("hold k%0d left", k), {16'd0, au_in_left}, 32'd0);
      step();
    end
    chk("hold idle done", {31'd0, done}, 32'd1);
    chk("hold idle ready", {31'd0, note_ready}, 32'd1);
    step();
    note_valid = 1'b0;
    play_check(vb, "held");

    // Asynchronous reset in the middle of PLAY.
    drive(vecs[0]);
    note_valid = 1'b1;
    step();
    note_valid = 1'b0;
    repeat (5) step();
    chk("pre-rst left", {16'd0, au_in_left}, 32'h8800);
    rst = 1'b1;
    #1;
    chk("rst left", {16'd0, au_in_left}, 32'd0);
    chk("rst right", {16'd0, au_in_right}, 32'd0);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst ready", {31'd0, note_ready}, 32'd1);
    step();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("post-rst k%0d done", k), {31'd0, done}, 32'd0);
      chk($sformatf("post-rst k%0d busy", k), {31'd0, busy}, 32'd0);
    end
    send_and_check(vecs[0], "after-rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
